// File: rtl/seg_display_scanner.sv
// Multiplexed seven-segment display controller with a hex or unsigned-decimal mode.
// Decimal values are converted by a sequential double-dabble, one bit per clock.
module seg_display_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic                    load,
    input  logic                    mode,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic                    busy,
    output logic                    ovf,
    output logic [7:0]              segments,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int W       = 4 * NUM_DIGITS;
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int DWELL_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int CNT_W   = $clog2(W);

    typedef enum logic {
        S_IDLE,
        S_CONV
    } state_t;

    state_t                state_q, state_d;
    logic [W-1:0]          buf_q, buf_d;
    logic [W-1:0]          bin_q, bin_d;
    logic [W-1:0]          bcd_q, bcd_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  sticky_q, sticky_d;
    logic [NUM_DIGITS-1:0] dp_q, dp_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                  blank_q, blank_d;
    logic                  pend_blank_q, pend_blank_d;
    logic                  ovf_q, ovf_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DWELL_W-1:0]    dwell_q, dwell_d;
    logic [7:0]            segments_q, segments_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic [W-1:0]          bcd_adj;
    logic [W-1:0]          bcd_next;
    logic                  bcd_carry;
    logic [NUM_DIGITS-1:0] lz;
    logic                  seen_nz;
    logic [3:0]            nib;
    logic                  sel_dp;
    logic                  sel_lz;
    logic [7:0]            base;

    function automatic logic [7:0] encode(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // One double-dabble step: add-3 correction, then shift the next binary bit in.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
        bcd_carry = bcd_adj[W-1];
        bcd_next  = {bcd_adj[W-2:0], bin_q[W-1]};
    end

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        cnt_d        = cnt_q;
        sticky_d     = sticky_q;
        dp_d         = dp_q;
        pend_dp_d    = pend_dp_q;
        blank_d      = blank_q;
        pend_blank_d = pend_blank_q;
        ovf_d        = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    if (mode) begin
                        state_d      = S_CONV;
                        bin_d        = data_in;
                        bcd_d        = '0;
                        cnt_d        = '0;
                        sticky_d     = 1'b0;
                        pend_dp_d    = dp_in;
                        pend_blank_d = blank_lz;
                    end else begin
                        buf_d   = data_in;
                        dp_d    = dp_in;
                        blank_d = blank_lz;
                        ovf_d   = 1'b0;
                    end
                end
            end
            S_CONV: begin
                bin_d    = bin_q << 1;
                bcd_d    = bcd_next;
                sticky_d = sticky_q | bcd_carry;
                cnt_d    = cnt_q + 1'b1;
                // Display flags are swapped in with the result so the old value stays coherent.
                if (cnt_q == CNT_W'(W - 1)) begin
                    state_d = S_IDLE;
                    buf_d   = bcd_next;
                    ovf_d   = sticky_q | bcd_carry;
                    dp_d    = pend_dp_q;
                    blank_d = pend_blank_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dwell_d = dwell_q + 1'b1;
        idx_d   = idx_q;
        if (dwell_q == DWELL_W'(SCAN_CYCLES - 1)) begin
            dwell_d = '0;
            idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // A digit is a leading zero when it and every more significant nibble are zero.
    always_comb begin
        seen_nz = 1'b0;
        lz      = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seen_nz = seen_nz | (|buf_q[i*4 +: 4]);
            lz[i]   = ~seen_nz;
        end
    end

    always_comb begin
        nib    = 4'h0;
        sel_dp = 1'b0;
        sel_lz = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib    = buf_q[i*4 +: 4];
                sel_dp = dp_q[i];
                sel_lz = lz[i] && (i != 0);
            end
        end
        if (ovf_q) begin
            base = 8'hBF;
        end else if (blank_q && sel_lz) begin
            base = 8'hFF;
        end else begin
            base = encode(nib);
        end
        segments_d = {~sel_dp, base[6:0]};
        an_d       = ~(NUM_DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            buf_q        <= '0;
            bin_q        <= '0;
            bcd_q        <= '0;
            cnt_q        <= '0;
            sticky_q     <= 1'b0;
            dp_q         <= '0;
            pend_dp_q    <= '0;
            blank_q      <= 1'b0;
            pend_blank_q <= 1'b0;
            ovf_q        <= 1'b0;
            idx_q        <= '0;
            dwell_q      <= '0;
            segments_q   <= 8'hFF;
            an_q         <= '1;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            bin_q        <= bin_d;
            bcd_q        <= bcd_d;
            cnt_q        <= cnt_d;
            sticky_q     <= sticky_d;
            dp_q         <= dp_d;
            pend_dp_q    <= pend_dp_d;
            blank_q      <= blank_d;
            pend_blank_q <= pend_blank_d;
            ovf_q        <= ovf_d;
            idx_q        <= idx_d;
            dwell_q      <= dwell_d;
            segments_q   <= segments_d;
            an_q         <= an_d;
        end
    end

    assign busy     = (state_q == S_CONV);
    assign ovf      = ovf_q;
    assign segments = segments_q;
    assign an       = an_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed self-checking bench for seg_display_scanner with 4 digits and a 2-cycle dwell.
module tb_seg_display_scanner;

    localparam int ND = 4;
    localparam int SC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   data_in;
    logic          load;
    logic          mode;
    logic          blank_lz;
    logic [ND-1:0] dp_in;
    logic          busy;
    logic          ovf;
    logic [7:0]    segments;
    logic [ND-1:0] an;

    int checks = 0;
    int errors = 0;
    int n;

    logic [3:0] seq_an  [8] = '{4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7, 4'hE};
    logic [7:0] seq_seg [8] = '{8'h8E, 8'h88, 8'h88, 8'hA4, 8'hA4, 8'hF9, 8'hF9, 8'h8E};

    seg_display_scanner #(.NUM_DIGITS(ND), .SCAN_CYCLES(SC)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .load     (load),
        .mode     (mode),
        .blank_lz (blank_lz),
        .dp_in    (dp_in),
        .busy     (busy),
        .ovf      (ovf),
        .segments (segments),
        .an       (an)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one load cycle; returns sampled just after the capturing edge.
    task automatic applyStimulus(input logic [15:0] d, input logic m, input logic b,
                                 input logic [3:0] dp);
        data_in  = d;
        mode     = m;
        blank_lz = b;
        dp_in    = dp;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    task automatic waitBusy(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            cycles++;
            tick();
        end
    endtask

    task automatic checkDigit(input string tag, input int d, input logic [7:0] exp);
        int         k;
        logic [3:0] want_an;
        want_an = ~(4'b0001 << d);
        k = 0;
        while (an !== want_an && k < 20) begin
            tick();
            k++;
        end
        checkOutput({tag, " an"}, {4'h0, an}, {4'h0, want_an});
        checkOutput({tag, " seg"}, segments, exp);
    endtask

    task automatic checkDigits(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                               input logic [7:0] e1, input logic [7:0] e0);
        checkDigit({tag, " d0"}, 0, e0);
        checkDigit({tag, " d1"}, 1, e1);
        checkDigit({tag, " d2"}, 2, e2);
        checkDigit({tag, " d3"}, 3, e3);
    endtask

    function automatic logic [7:0] oldSeg(input logic [3:0] a);
        case (a)
            4'hE:    return 8'h8E;
            4'hD:    return 8'h88;
            4'hB:    return 8'hA4;
            4'h7:    return 8'hF9;
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        data_in  = '0;
        mode     = 1'b0;
        blank_lz = 1'b0;
        dp_in    = '0;
        repeat (3) tick();
        checkOutput("reset seg", segments, 8'hFF);
        checkOutput("reset an", {4'h0, an}, 8'h0F);
        checkOutput("reset busy", {7'h0, busy}, 8'h00);
        checkOutput("reset ovf", {7'h0, ovf}, 8'h00);

        // Release reset with a hex load on the same first edge.
        rst = 1'b0;
        applyStimulus(16'h12AF, 1'b0, 1'b0, 4'b0000);
        checkOutput("first an", {4'h0, an}, 8'h0E);
        checkOutput("first seg", segments, 8'hC0);
        for (int k = 0; k < 8; k++) begin
            tick();
            checkOutput($sformatf("scan%0d an", k), {4'h0, an}, {4'h0, seq_an[k]});
            checkOutput($sformatf("scan%0d seg", k), segments, seq_seg[k]);
            checkOutput($sformatf("scan%0d busy", k), {7'h0, busy}, 8'h00);
        end

        // Decimal 1234: old digits remain on display while converting.
        applyStimulus(16'h04D2, 1'b1, 1'b0, 4'b0000);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            if (n == 2 || n == 9) begin
                checkOutput($sformatf("conv old seg %0d", n), segments, oldSeg(an));
            end
            n++;
            tick();
        end
        checkOutput("1234 busy cycles", 8'(n), 8'd16);
        tick();
        checkOutput("1234 ovf", {7'h0, ovf}, 8'h00);
        checkDigits("1234", 8'hF9, 8'hA4, 8'hB0, 8'h99);

        // Decimal overflow, then the largest value that fits.
        applyStimulus(16'h2710, 1'b1, 1'b1, 4'b0000);
        waitBusy(n);
        checkOutput("10000 busy cycles", 8'(n), 8'd16);
        tick();
        checkOutput("10000 ovf", {7'h0, ovf}, 8'h01);
        checkDigits("10000", 8'hBF, 8'hBF, 8'hBF, 8'hBF);
        applyStimulus(16'd9999, 1'b1, 1'b0, 4'b0000);
        waitBusy(n);
        tick();
        checkOutput("9999 ovf", {7'h0, ovf}, 8'h00);
        checkDigits("9999", 8'h90, 8'h90, 8'h90, 8'h90);

        // Leading-zero blanking in hex mode.
        applyStimulus(16'h0005, 1'b0, 1'b1, 4'b0000);
        checkOutput("hex busy", {7'h0, busy}, 8'h00);
        tick();
        checkDigits("blank 0005", 8'hFF, 8'hFF, 8'hFF, 8'h92);
        applyStimulus(16'h0000, 1'b0, 1'b1, 4'b0000);
        tick();
        checkDigits("blank 0000", 8'hFF, 8'hFF, 8'hFF, 8'hC0);
        applyStimulus(16'h0500, 1'b0, 1'b1, 4'b0000);
        tick();
        checkDigits("blank 0500", 8'hFF, 8'h92, 8'hC0, 8'hC0);

        // Decimal point on digit 2 only.
        applyStimulus(16'h0000, 1'b0, 1'b0, 4'b0100);
        tick();
        checkDigits("dp", 8'hC0, 8'h40, 8'hC0, 8'hC0);

        // A hex load during conversion must be ignored.
        applyStimulus(16'd42, 1'b1, 1'b0, 4'b0000);
        repeat (4) tick();
        data_in = 16'hFFFF;
        mode    = 1'b0;
        load    = 1'b1;
        tick();
        load    = 1'b0;
        waitBusy(n);
        checkOutput("ignored load busy cycles", 8'(n), 8'd11);
        tick();
        checkDigits("42", 8'hC0, 8'hC0, 8'h99, 8'hA4);

        // Reset in the middle of a conversion aborts it and clears the buffer.
        applyStimulus(16'd42, 1'b1, 1'b0, 4'b0000);
        repeat (7) tick();
        checkOutput("pre-abort busy", {7'h0, busy}, 8'h01);
        rst = 1'b1;
        tick();
        checkOutput("abort busy", {7'h0, busy}, 8'h00);
        checkOutput("abort an", {4'h0, an}, 8'h0F);
        checkOutput("abort seg", segments, 8'hFF);
        rst = 1'b0;
        tick();
        checkDigits("after abort", 8'hC0, 8'hC0, 8'hC0, 8'hC0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
